// File: rtl/fc_argmax_engine_if.sv
// Stream-in / result-out bundle of the fully-connected arg-max engine.
// The master drives start and input beats; the slave (engine) returns ready and results.
interface fc_argmax_engine_if #(
    parameter int M      = 2,
    parameter int DATA_W = 16,
    parameter int ACC_W  = 40
);
    localparam int IDX_W = (M > 1) ? $clog2(M) : 1;

    logic              start;
    logic              load_weights;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              busy;
    logic              weights_valid;
    logic              result_valid;
    logic [IDX_W-1:0]  class_idx;
    logic [M-1:0]      class_onehot;
    logic [ACC_W-1:0]  max_score;

    modport master (
        output start, load_weights, in_valid, in_data,
        input  in_ready, busy, weights_valid, result_valid, class_idx, class_onehot, max_score
    );

    modport slave (
        input  start, load_weights, in_valid, in_data,
        output in_ready, busy, weights_valid, result_valid, class_idx, class_onehot, max_score
    );
endinterface

// File: rtl/fc_argmax_engine.sv
// Fully-connected layer plus arg-max: loads x (and optionally W, b), one saturating MAC per cycle,
// result_valid M*(N+1)+1 cycles after the last beat; in_ready is high only in the load states.
module fc_argmax_engine #(
    parameter int N      = 3,
    parameter int M      = 2,
    parameter int DATA_W = 16,
    parameter int ACC_W  = 40
) (
    input  logic              clk,
    input  logic              reset,
    fc_argmax_engine_if.slave bus
);
    localparam int IDX_W = (M > 1) ? $clog2(M) : 1;
    localparam int X_AW  = (N > 1) ? $clog2(N) : 1;
    localparam int W_AW  = (N * M > 1) ? $clog2(N * M) : 1;
    localparam int CNT_W = $clog2(N * M + 1);
    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic [M-1:0] ONEHOT_LSB = M'(1);

    typedef enum logic [2:0] {
        S_IDLE, S_LD_X, S_LD_W, S_LD_B, S_MAC, S_FIN, S_DONE
    } state_t;

    state_t r_state, w_next;

    logic [CNT_W-1:0]         r_cnt;
    logic [X_AW-1:0]          r_n;
    logic [IDX_W-1:0]         r_m;
    logic                     r_wload;
    logic                     r_wvalid;
    logic signed [ACC_W-1:0]  r_acc;
    logic signed [ACC_W-1:0]  r_best;
    logic [IDX_W-1:0]         r_bidx;
    logic [IDX_W-1:0]         r_class_idx;
    logic [M-1:0]             r_onehot;
    logic signed [ACC_W-1:0]  r_max;

    logic signed [DATA_W-1:0] r_x [N];
    logic signed [DATA_W-1:0] r_w [N*M];
    logic signed [DATA_W-1:0] r_b [M];

    logic                      w_in_ready;
    logic                      w_x_last, w_w_last, w_b_last, w_n_last, w_m_last;
    logic [CNT_W-1:0]          w_widx;
    logic signed [2*DATA_W-1:0] w_prod;
    logic signed [ACC_W-1:0]   w_mac_sum;
    logic signed [ACC_W-1:0]   w_fin;
    logic                      w_take;
    logic [IDX_W-1:0]          w_win_idx;
    logic signed [ACC_W-1:0]   w_win_score;

    // One extra bit of headroom detects overflow; clamp instead of wrapping.
    function automatic logic signed [ACC_W-1:0] sat_add(input logic signed [ACC_W-1:0] a,
                                                        input logic signed [ACC_W-1:0] b);
        logic signed [ACC_W:0] s;
        s = {a[ACC_W-1], a} + {b[ACC_W-1], b};
        if (s[ACC_W] != s[ACC_W-1])
            return s[ACC_W] ? ACC_MIN : ACC_MAX;
        return s[ACC_W-1:0];
    endfunction

    assign w_in_ready = (r_state == S_LD_X) || (r_state == S_LD_W) || (r_state == S_LD_B);
    assign w_x_last   = (r_cnt == CNT_W'(N - 1));
    assign w_w_last   = (r_cnt == CNT_W'(N * M - 1));
    assign w_b_last   = (r_cnt == CNT_W'(M - 1));
    assign w_n_last   = (r_n == X_AW'(N - 1));
    assign w_m_last   = (r_m == IDX_W'(M - 1));

    // Weights are stored feature-major: W[n*M + m].
    assign w_widx      = CNT_W'(r_n) * CNT_W'(M) + CNT_W'(r_m);
    assign w_prod      = r_x[r_n] * r_w[W_AW'(w_widx)];
    assign w_mac_sum   = sat_add(r_acc, ACC_W'(w_prod));
    assign w_fin       = sat_add(r_acc, ACC_W'(r_b[r_m]));
    assign w_take      = (r_m == '0) || (w_fin > r_best);
    assign w_win_idx   = w_take ? r_m : r_bidx;
    assign w_win_score = w_take ? w_fin : r_best;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (bus.start) w_next = S_LD_X;
            S_LD_X: if (bus.in_valid && w_x_last) w_next = r_wload ? S_LD_W : S_MAC;
            S_LD_W: if (bus.in_valid && w_w_last) w_next = S_LD_B;
            S_LD_B: if (bus.in_valid && w_b_last) w_next = S_MAC;
            S_MAC:  if (w_n_last) w_next = S_FIN;
            S_FIN:  w_next = w_m_last ? S_DONE : S_MAC;
            S_DONE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_n         <= '0;
            r_m         <= '0;
            r_wload     <= 1'b0;
            r_wvalid    <= 1'b0;
            r_acc       <= '0;
            r_best      <= '0;
            r_bidx      <= '0;
            r_class_idx <= '0;
            r_onehot    <= '0;
            r_max       <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    r_n   <= '0;
                    r_m   <= '0;
                    r_acc <= '0;
                    if (bus.start) r_wload <= bus.load_weights | ~r_wvalid;
                end
                S_LD_X: if (bus.in_valid) begin
                    r_cnt <= w_x_last ? '0 : r_cnt + 1'b1;
                    if (w_x_last && r_wload) r_wvalid <= 1'b0;
                end
                S_LD_W: if (bus.in_valid) r_cnt <= w_w_last ? '0 : r_cnt + 1'b1;
                S_LD_B: if (bus.in_valid) begin
                    r_cnt <= w_b_last ? '0 : r_cnt + 1'b1;
                    if (w_b_last) r_wvalid <= 1'b1;
                end
                S_MAC: begin
                    r_acc <= w_mac_sum;
                    r_n   <= w_n_last ? '0 : r_n + 1'b1;
                end
                S_FIN: begin
                    r_acc  <= '0;
                    r_best <= w_win_score;
                    r_bidx <= w_win_idx;
                    // Results are committed on the edge into DONE so they are visible with result_valid.
                    if (w_m_last) begin
                        r_class_idx <= w_win_idx;
                        r_onehot    <= ONEHOT_LSB << w_win_idx;
                        r_max       <= w_win_score;
                    end else begin
                        r_m <= r_m + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Operand storage survives reset so retained weights need no reload logic of their own.
    always_ff @(posedge clk) begin
        if (bus.in_valid) begin
            if (r_state == S_LD_X) r_x[X_AW'(r_cnt)]  <= $signed(bus.in_data);
            if (r_state == S_LD_W) r_w[W_AW'(r_cnt)]  <= $signed(bus.in_data);
            if (r_state == S_LD_B) r_b[IDX_W'(r_cnt)] <= $signed(bus.in_data);
        end
    end

    assign bus.in_ready      = w_in_ready;
    assign bus.busy          = (r_state != S_IDLE);
    assign bus.weights_valid = r_wvalid;
    assign bus.result_valid  = (r_state == S_DONE);
    assign bus.class_idx     = r_class_idx;
    assign bus.class_onehot  = r_onehot;
    assign bus.max_score     = r_max;
endmodule
